// File: rtl/object_spawn_scheduler.sv
// Per-frame sweep of object bank slots 1..N-1: retires off-screen objects, scores them
// and spawns new ones at an LFSR-chosen column. Optional macro: DIFFICULTY_RAMP_EN.
module object_spawn_scheduler #(
  parameter int          OBJECT_BANK_SIZE = 16,
  parameter int          SCREEN_V         = 600,
  parameter int          SPAWN_H_RANGE    = 768,
  parameter int          SPAWN_INTERVAL   = 64,
  parameter logic [15:0] LFSR_SEED        = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_start,
  input  logic        game_over,
  output logic [3:0]  rd_addr,
  input  logic [26:0] rd_data,
  output logic        wr_en,
  output logic [3:0]  wr_addr,
  output logic [26:0] wr_data,
  output logic        busy,
  output logic [15:0] score,
  output logic        overrun
);

  localparam int          TW          = $clog2(SPAWN_INTERVAL + 1);
  localparam logic [3:0]  LAST_SLOT   = 4'(OBJECT_BANK_SIZE - 1);
  localparam logic [9:0]  RETIRE_V    = 10'(SCREEN_V);
  localparam logic [9:0]  H_RANGE     = 10'(SPAWN_H_RANGE);
  localparam logic [26:0] EXISTS_MASK = 27'h0100000;

  typedef enum logic [2:0] {IDLE, READ, CHECK, SPAWN, DONE} state_t;

  state_t        state_q, state_d;
  logic [3:0]    rd_addr_q, rd_addr_d;
  logic          wr_en_q, wr_en_d;
  logic [3:0]    wr_addr_q, wr_addr_d;
  logic [26:0]   wr_data_q, wr_data_d;
  logic          busy_q, busy_d;
  logic [15:0]   score_q, score_d;
  logic          overrun_q, overrun_d;
  logic [TW-1:0] spawn_timer_q, spawn_timer_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [3:0]    free_slot_q, free_slot_d;
  logic          free_valid_q, free_valid_d;

  logic [TW-1:0] reload_val;
  logic          lfsr_fb;
  logic [9:0]    spawn_h;
  logic [26:0]   spawn_entry;

  assign lfsr_fb     = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
  assign spawn_h     = (lfsr_q[9:0] >= H_RANGE) ? (lfsr_q[9:0] - H_RANGE) : lfsr_q[9:0];
  assign spawn_entry = {lfsr_q[15], lfsr_q[14], lfsr_q[11:10], 2'b00, 1'b1, 10'd0, spawn_h};

`ifdef DIFFICULTY_RAMP_EN
  localparam logic [TW-1:0] INTERVAL_INIT  = TW'(SPAWN_INTERVAL);
  localparam logic [TW-1:0] INTERVAL_FLOOR = TW'(8);

  logic [TW-1:0] interval_q, interval_d;
  logic [2:0]    ramp_cnt_q, ramp_cnt_d;

  // Every eighth scored retirement shortens the spawn interval, down to the floor.
  always_comb begin
    interval_d = interval_q;
    ramp_cnt_d = ramp_cnt_q;
    if (score_d != score_q) begin
      ramp_cnt_d = ramp_cnt_q + 3'd1;
      if (ramp_cnt_q == 3'd7 && interval_q > INTERVAL_FLOOR) begin
        interval_d = interval_q - TW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      interval_q <= INTERVAL_INIT;
      ramp_cnt_q <= 3'd0;
    end else begin
      interval_q <= interval_d;
      ramp_cnt_q <= ramp_cnt_d;
    end
  end

  assign reload_val = interval_q - TW'(1);
`else
  assign reload_val = TW'(SPAWN_INTERVAL - 1);
`endif

  always_comb begin
    state_d       = state_q;
    rd_addr_d     = rd_addr_q;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    score_d       = score_q;
    overrun_d     = overrun_q;
    spawn_timer_d = spawn_timer_q;
    lfsr_d        = {lfsr_fb, lfsr_q[15:1]};
    free_slot_d   = free_slot_q;
    free_valid_d  = free_valid_q;

    if (frame_start && busy_q) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (state_q == DONE) begin
          rd_addr_d = 4'd0;
        end
        if (frame_start) begin
          rd_addr_d     = 4'd1;
          free_valid_d  = 1'b0;
          spawn_timer_d = (spawn_timer_q == '0) ? '0 : spawn_timer_q - TW'(1);
          state_d       = READ;
        end
      end
      READ: begin
        state_d = CHECK;
      end
      CHECK: begin
        // rd_addr_q still holds the slot whose entry is on rd_data this cycle.
        if (rd_data[20] && rd_data[19:10] >= RETIRE_V) begin
          wr_en_d   = 1'b1;
          wr_addr_d = rd_addr_q;
          wr_data_d = rd_data & ~EXISTS_MASK;
          if (!game_over && score_q != 16'hFFFF) begin
            score_d = score_q + 16'd1;
          end
        end else if (!rd_data[20] && !free_valid_q) begin
          free_slot_d  = rd_addr_q;
          free_valid_d = 1'b1;
        end
        if (rd_addr_q == LAST_SLOT) begin
          state_d = SPAWN;
        end else begin
          rd_addr_d = rd_addr_q + 4'd1;
          state_d   = READ;
        end
      end
      SPAWN: begin
        if (spawn_timer_q == '0 && free_valid_q && !game_over) begin
          wr_en_d       = 1'b1;
          wr_addr_d     = free_slot_q;
          wr_data_d     = spawn_entry;
          spawn_timer_d = reload_val;
        end
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == READ) || (state_d == CHECK) || (state_d == SPAWN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      rd_addr_q     <= 4'd0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= 4'd0;
      wr_data_q     <= 27'd0;
      busy_q        <= 1'b0;
      score_q       <= 16'd0;
      overrun_q     <= 1'b0;
      spawn_timer_q <= '0;
      lfsr_q        <= LFSR_SEED;
      free_slot_q   <= 4'd0;
      free_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      rd_addr_q     <= rd_addr_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      busy_q        <= busy_d;
      score_q       <= score_d;
      overrun_q     <= overrun_d;
      spawn_timer_q <= spawn_timer_d;
      lfsr_q        <= lfsr_d;
      free_slot_q   <= free_slot_d;
      free_valid_q  <= free_valid_d;
    end
  end

  assign rd_addr = rd_addr_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;
  assign score   = score_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_object_spawn_scheduler.sv
// Self-checking bench for object_spawn_scheduler: a behavioural bank plus a per-pass
// reference model that predicts every write, its cycle, score, busy and overrun.
`timescale 1ns/1ps
module tb_object_spawn_scheduler;

  localparam logic [15:0] SEED   = 16'hACE1;
  localparam logic [26:0] EXISTS = 27'h0100000;

  typedef struct { int off; logic [3:0] addr; logic [26:0] data; logic [15:0] lf; } wrec_t;
  typedef struct { int off; logic [3:0] addr; logic [26:0] data; bit spawn; } wexp_t;
  typedef struct { int slot; int posv; bit ex; bit go; int exp_writes; int exp_inc; } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        frame_start = 1'b0;
  logic        game_over = 1'b0;
  logic [3:0]  rd_addr, wr_addr;
  logic [26:0] rd_data, wr_data;
  logic        wr_en, busy, overrun;
  logic [15:0] score;

  object_spawn_scheduler dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .game_over(game_over),
    .rd_addr(rd_addr), .rd_data(rd_data), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .score(score), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Object bank: one-cycle read latency, write port, and whole-image loads from the bench.
  logic [26:0] mem [16];
  logic [26:0] img [16];
  int load_seq = 0;
  int load_seen = 0;
  always @(posedge clk) begin
    if (load_seq != load_seen) begin
      for (int i = 0; i < 16; i++) mem[i] <= img[i];
      load_seen <= load_seq;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

  // Reference LFSR: advances once per clock, restarts at the seed on reset.
  logic [15:0] lfsr_m, lfsr_prev;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_m    <= SEED;
      lfsr_prev <= SEED;
    end else begin
      lfsr_prev <= lfsr_m;
      lfsr_m    <= lfsrStep(lfsr_m);
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor on the falling edge: write log with cycle offsets, busy count, read addresses.
  wrec_t      wlog[$];
  int         busy_cnt = 0;
  int         t0 = 0;
  int         mon_off;
  logic [3:0] rdseq [64];
  always @(negedge clk) begin
    if (rst_n) begin
      mon_off = cyc - t0;
      if (wr_en) wlog.push_back('{mon_off, wr_addr, wr_data, lfsr_prev});
      if (busy) busy_cnt++;
      if (mon_off >= 0 && mon_off < 64) rdseq[mon_off] = rd_addr;
    end
  end

  int total = 0;
  int bad = 0;
  int score_m = 0;
  int timer_m = 0;
  bit ovr_m = 1'b0;

  function automatic logic [15:0] lfsrStep(input logic [15:0] l);
    return {^(l & 16'h002D), l[15:1]};
  endfunction

  function automatic logic [26:0] spawnEntry(input logic [15:0] l);
    int h = int'(l[9:0]);
    if (h >= 768) h -= 768;
    return {l[15], l[14], l[11:10], 2'b00, 1'b1, 10'd0, 10'(h)};
  endfunction

  function automatic logic [26:0] mkEntry(input bit ex, input int posv, input logic [9:0] h);
    return {6'b101101, ex, 10'(posv), h};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic loadBank();
    load_seq++;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic fillOccupied();
    for (int i = 0; i < 16; i++) img[i] = mkEntry(1'b1, (i == 0) ? 700 : 100, 10'h0AA);
  endtask

  // One frame pass: predict from the bank contents, pulse frame_start, then compare.
  task automatic applyStimulus(input bit go, input int second_fs, input string tag,
                               output int nw, output logic [3:0] last_addr,
                               output logic [26:0] last_data);
    wexp_t       ex[$];
    logic [26:0] e;
    wrec_t       w;
    int          free_k;
    int          ws;
    int          bs;
    bit          sweep_ok;
    free_k   = -1;
    sweep_ok = 1'b1;
    @(negedge clk);
    game_over = go;
    for (int k = 1; k < 16; k++) begin
      e = mem[k];
      if (e[20] && e[19:10] >= 10'd600) begin
        ex.push_back('{2 * k + 1, 4'(k), e & ~EXISTS, 1'b0});
        if (!go && score_m < 65535) score_m++;
      end else if (!e[20] && free_k < 0) begin
        free_k = k;
      end
    end
    timer_m = (timer_m > 0) ? timer_m - 1 : 0;
    if (timer_m == 0 && free_k >= 0 && !go) begin
      ex.push_back('{32, 4'(free_k), 27'd0, 1'b1});
      timer_m = 63;
    end
    if (second_fs >= 1 && second_fs <= 31) ovr_m = 1'b1;
    ws = wlog.size();
    bs = busy_cnt;
    t0 = cyc;
    frame_start = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      frame_start = (n == second_fs);
    end
    nw = wlog.size() - ws;
    last_addr = 4'd0;
    last_data = 27'd0;
    checkOutput({tag, " write count"}, nw, ex.size());
    for (int i = 0; i < ex.size() && i < nw; i++) begin
      w = wlog[ws + i];
      checkOutput({tag, " write cycle"}, w.off, ex[i].off);
      checkOutput({tag, " write addr"}, {28'd0, w.addr}, {28'd0, ex[i].addr});
      checkOutput({tag, " write data"}, {5'd0, w.data},
                  {5'd0, ex[i].spawn ? spawnEntry(w.lf) : ex[i].data});
    end
    if (nw > 0) begin
      last_addr = wlog[wlog.size() - 1].addr;
      last_data = wlog[wlog.size() - 1].data;
    end
    for (int k = 1; k < 16; k++) if (rdseq[2 * k - 1] !== 4'(k)) sweep_ok = 1'b0;
    checkOutput({tag, " busy cycles"}, busy_cnt - bs, 31);
    checkOutput({tag, " rd sweep"}, {31'd0, sweep_ok}, 1);
    checkOutput({tag, " idle after"}, {31'd0, busy}, 0);
    checkOutput({tag, " score"}, {16'd0, score}, score_m);
    checkOutput({tag, " overrun"}, {31'd0, overrun}, {31'd0, ovr_m});
  endtask

  initial begin
    vec_t        vecs [6];
    int          nw;
    logic [3:0]  la;
    logic [26:0] ld;
    int          base;

    vecs[0] = '{5, 600, 1'b1, 1'b0, 1, 1};
    vecs[1] = '{6, 599, 1'b1, 1'b0, 0, 0};
    vecs[2] = '{15, 1023, 1'b1, 1'b0, 1, 1};
    vecs[3] = '{1, 600, 1'b1, 1'b0, 1, 1};
    vecs[4] = '{2, 650, 1'b1, 1'b1, 1, 0};
    vecs[5] = '{9, 700, 1'b0, 1'b0, 0, 0};

    #1 rst_n = 1'b0;
    for (int i = 0; i < 16; i++) img[i] = 27'd0;
    load_seq++;
    repeat (3) @(negedge clk);
    checkOutput("reset busy", {31'd0, busy}, 0);
    checkOutput("reset score", {16'd0, score}, 0);
    checkOutput("reset overrun", {31'd0, overrun}, 0);
    checkOutput("reset wr_en", {31'd0, wr_en}, 0);
    checkOutput("reset rd_addr", {28'd0, rd_addr}, 0);
    checkOutput("reset wr_data", {5'd0, wr_data}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Empty bank: first pass spawns into slot 1.
    applyStimulus(1'b0, -1, "empty", nw, la, ld);
    checkOutput("empty spawn count", nw, 1);
    checkOutput("empty spawn slot", {28'd0, la}, 1);
    checkOutput("empty spawn exists", {31'd0, ld[20]}, 1);
    checkOutput("empty spawn posV", {22'd0, ld[19:10]}, 0);

    // Single-slot vectors on an otherwise full bank (slot 0 deliberately off-screen).
    for (int v = 0; v < 6; v++) begin
      fillOccupied();
      img[vecs[v].slot] = mkEntry(vecs[v].ex, vecs[v].posv, 10'h155);
      loadBank();
      base = score_m;
      applyStimulus(vecs[v].go, -1, $sformatf("vec%0d", v), nw, la, ld);
      checkOutput($sformatf("vec%0d writes", v), nw, vecs[v].exp_writes);
      checkOutput($sformatf("vec%0d score step", v), {16'd0, score}, base + vecs[v].exp_inc);
    end
    game_over = 1'b0;

    // Run the spawn timer down with a full bank.
    fillOccupied();
    loadBank();
    for (int i = 0; i < 80 && timer_m != 0; i++) applyStimulus(1'b0, -1, "drain", nw, la, ld);
    applyStimulus(1'b0, -1, "full expired", nw, la, ld);
    checkOutput("full bank no spawn", nw, 0);
    img[3] = 27'd0;
    loadBank();
    applyStimulus(1'b1, -1, "gameover free", nw, la, ld);
    checkOutput("gameover no spawn", nw, 0);
    applyStimulus(1'b0, -1, "slot3 spawn", nw, la, ld);
    checkOutput("slot3 spawn count", nw, 1);
    checkOutput("slot3 spawn slot", {28'd0, la}, 3);

    // Second frame_start during a pass.
    applyStimulus(1'b0, 10, "overrun", nw, la, ld);
    applyStimulus(1'b0, -1, "overrun sticky", nw, la, ld);

    // Randomised passes against the model.
    for (int p = 0; p < 30; p++) begin
      for (int k = 0; k < 16; k++) begin
        img[k] = mem[k];
        if ($urandom_range(2) == 0) img[k] = 27'($urandom);
      end
      loadBank();
      applyStimulus($urandom_range(3) == 0, -1, $sformatf("rand%0d", p), nw, la, ld);
    end
    game_over = 1'b0;

    // Reset while slot 8 is being checked: its retire must never land.
    fillOccupied();
    img[8] = mkEntry(1'b1, 700, 10'h077);
    img[4] = 27'd0;
    loadBank();
    @(negedge clk);
    t0 = cyc;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset wr_en", {31'd0, wr_en}, 0);
    checkOutput("midreset busy", {31'd0, busy}, 0);
    checkOutput("midreset score", {16'd0, score}, 0);
    checkOutput("midreset overrun", {31'd0, overrun}, 0);
    score_m = 0;
    timer_m = 0;
    ovr_m   = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("midreset slot8 kept", {31'd0, mem[8][20]}, 1);
    applyStimulus(1'b0, -1, "after reset", nw, la, ld);
    checkOutput("after reset spawn slot", {28'd0, la}, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
